// File: rtl/iter_div_responder_if.sv
// iter_div_responder_if: dividend/divisor request channels and the result channel between the ALU (master) and the divider (slave).
interface iter_div_responder_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;
  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid, s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  s_axis_dividend_tready, s_axis_divisor_tready, m_axis_dout_tdata, m_axis_dout_tvalid
  );
  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid, s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output s_axis_dividend_tready, s_axis_divisor_tready, m_axis_dout_tdata, m_axis_dout_tvalid
  );
endinterface

// File: rtl/iter_div_responder.sv
// iter_div_responder: radix-2 restoring divider; ports clk, reset, bus (slave: dividend/divisor in, {quotient,remainder} out).
module iter_div_responder #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input logic clk,
  input logic reset,
  iter_div_responder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state;
  logic             sa, sb;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [CW-1:0]    cnt;
  logic             go, ge, a_neg, b_neg;
  logic [WIDTH-1:0] a, b, q_nx, r_nx;
  logic [WIDTH:0]   sh;
  assign a     = bus.s_axis_dividend_tdata;
  assign b     = bus.s_axis_divisor_tdata;
  assign go    = state == IDLE && bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid;
  assign bus.s_axis_dividend_tready = go;
  assign bus.s_axis_divisor_tready  = go;
  assign a_neg = SIGNED && a[WIDTH-1];
  assign b_neg = SIGNED && b[WIDTH-1];
  // rem < dvs always holds, so the shifted remainder needs one extra bit and the kept difference fits back in WIDTH
  assign sh    = {rem, quo[WIDTH-1]};
  assign ge    = sh >= {1'b0, dvs};
  assign r_nx  = sh[WIDTH-1:0] - (ge ? dvs : '0);
  assign q_nx  = {quo[WIDTH-2:0], ge};
  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      sa                     <= 1'b0;
      sb                     <= 1'b0;
      quo                    <= '0;
      rem                    <= '0;
      dvs                    <= '0;
      cnt                    <= '0;
      bus.m_axis_dout_tdata  <= '0;
      bus.m_axis_dout_tvalid <= 1'b0;
    end else begin
      bus.m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE: if (go) begin
          sa    <= a_neg;
          sb    <= b_neg;
          quo   <= a_neg ? -a : a;
          dvs   <= b_neg ? -b : b;
          rem   <= '0;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: begin
          quo <= q_nx;
          rem <= r_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            bus.m_axis_dout_tdata  <= {(sa ^ sb) ? -q_nx : q_nx, sa ? -r_nx : r_nx};
            bus.m_axis_dout_tvalid <= 1'b1;
            state                  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_div_responder.sv
// tb_iter_div_responder: drives a signed and an unsigned divider with identical stimulus and checks both against an arithmetic model.
module tb_iter_div_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_d = '0, b_d = '0;
  logic        av = 1'b0, bv = 1'b0;
  int          errors = 0, checks = 0;
  always #5 clk = ~clk;
  iter_div_responder_if #(32) s_if ();
  iter_div_responder_if #(32) u_if ();
  assign s_if.s_axis_dividend_tdata  = a_d;
  assign s_if.s_axis_dividend_tvalid = av;
  assign s_if.s_axis_divisor_tdata   = b_d;
  assign s_if.s_axis_divisor_tvalid  = bv;
  assign u_if.s_axis_dividend_tdata  = a_d;
  assign u_if.s_axis_dividend_tvalid = av;
  assign u_if.s_axis_divisor_tdata   = b_d;
  assign u_if.s_axis_divisor_tvalid  = bv;
  iter_div_responder #(.WIDTH(32), .SIGNED(1'b1)) u_s (.clk(clk), .reset(reset), .bus(s_if));
  iter_div_responder #(.WIDTH(32), .SIGNED(1'b0)) u_u (.clk(clk), .reset(reset), .bus(u_if));
  function automatic logic [63:0] model(bit sgn, logic [31:0] a, logic [31:0] b);
    if (b == 0) return {(sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF, a};
    if (!sgn) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'd0};
    return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Called just after a negedge; returns just after the negedge following the tvalid pulse,
  // which is the earliest cycle a new transfer may be offered.
  task automatic run(logic [31:0] a, logic [31:0] b, bit keep, bit use_es, logic [63:0] es);
    logic [63:0] xs, xu;
    int n;
    xs = model(1'b1, a, b);
    xu = model(1'b0, a, b);
    a_d = a; b_d = b; av = 1'b1; bv = 1'b1;
    #1;
    chk("tready_xfer", {s_if.s_axis_dividend_tready, s_if.s_axis_divisor_tready, u_if.s_axis_dividend_tready, u_if.s_axis_divisor_tready}, 64'hF);
    @(posedge clk); #1;
    if (keep) begin
      a_d = $urandom; b_d = $urandom;
      #1;
      chk("tready_calc", {s_if.s_axis_dividend_tready, s_if.s_axis_divisor_tready, u_if.s_axis_dividend_tready, u_if.s_axis_divisor_tready}, 64'h0);
    end else begin
      av = 1'b0; bv = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (keep && n == 20) chk("tready_calc_mid", {s_if.s_axis_dividend_tready, u_if.s_axis_divisor_tready}, 64'h0);
    end while (!s_if.m_axis_dout_tvalid && n < 40);
    chk("latency", 64'(n), 64'd33);
    chk("tvalid_u", 64'(u_if.m_axis_dout_tvalid), 64'd1);
    chk("dout_s", s_if.m_axis_dout_tdata, xs);
    chk("dout_u", u_if.m_axis_dout_tdata, xu);
    if (use_es) chk("dout_directed", s_if.m_axis_dout_tdata, es);
    av = 1'b0; bv = 1'b0;
    @(negedge clk);
    chk("tvalid_pulse", {s_if.m_axis_dout_tvalid, u_if.m_axis_dout_tvalid}, 64'h0);
    chk("tdata_hold", s_if.m_axis_dout_tdata, xs);
  endtask
  initial begin
    int n;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("rst_tready", {s_if.s_axis_dividend_tready, s_if.s_axis_divisor_tready, u_if.s_axis_dividend_tready}, 64'h0);
    chk("rst_tvalid", {s_if.m_axis_dout_tvalid, u_if.m_axis_dout_tvalid}, 64'h0);
    chk("rst_tdata_s", s_if.m_axis_dout_tdata, 64'h0);
    chk("rst_tdata_u", u_if.m_axis_dout_tdata, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    run(32'd7, 32'd2, 1'b0, 1'b1, {32'h3, 32'h1});
    run(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    run(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, {32'hFFFF_FFFD, 32'h1});
    run(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, {32'h0, 32'hFFFF_FFFF});
    chk("unsigned_ff_by_16", u_if.m_axis_dout_tdata, {32'h0FFF_FFFF, 32'hF});
    run(32'd5, 32'd0, 1'b0, 1'b1, {32'hFFFF_FFFF, 32'h5});
    run(32'hFFFF_FFFB, 32'd0, 1'b0, 1'b1, {32'h1, 32'hFFFF_FFFB});
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, {32'h8000_0000, 32'h0});
    av = 1'b1; a_d = 32'd9; b_d = 32'd3;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(s_if.s_axis_dividend_tready | s_if.s_axis_divisor_tready | s_if.m_axis_dout_tvalid | u_if.s_axis_dividend_tready);
    end
    chk("one_valid_no_xfer", 64'(n), 64'd0);
    run(32'd9, 32'd3, 1'b0, 1'b1, {32'h3, 32'h0});
    a_d = 32'd1000; b_d = 32'd3; av = 1'b1; bv = 1'b1;
    @(posedge clk); #1;
    av = 1'b0; bv = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_tvalid", {s_if.m_axis_dout_tvalid, u_if.m_axis_dout_tvalid}, 64'h0);
    chk("abort_tdata", s_if.m_axis_dout_tdata, 64'h0);
    reset = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      n += int'(s_if.m_axis_dout_tvalid | u_if.m_axis_dout_tvalid);
    end
    chk("abort_no_result", 64'(n), 64'd0);
    run(32'd100, 32'd7, 1'b0, 1'b1, {32'hE, 32'h2});
    for (int i = 0; i < 250; i++) begin
      ra = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 15);
        1: rb = -$urandom_range(1, 15);
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run(ra, rb, i[0], 1'b0, 64'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
